// File: rtl/fifo_rollback_ctrl.sv
// fifo_rollback_ctrl
// Checkpoint controller for the rollback-capable instruction FIFO. When a
// speculative branch enters the queue, the controller records the FIFO write
// pointer. Checkpoints are freed in program order once their branch resolves
// correctly. On a mispredict, the saved pointer is replayed through Mable/Mark.
// On a flush, FifoClean is pulsed. Busy stalls the front-end while a rollback
// or a flush is in progress.
//
// Ports
//   Clk, Rest          clock (rising edge), asynchronous active-high reset
//   WrPtr              current FIFO write pointer, captured on snapshot
//   SnapReq/SnapAck    checkpoint allocation request / combinational grant
//   SnapId             id being allocated (valid with SnapAck)
//   ResValid/ResId/ResMiss  branch resolution (miss = rollback)
//   FlushReq           full pipeline flush
//   Mable, Mark        registered rollback strobe and restore pointer
//   FifoClean          registered clean strobe
//   Busy               registered, high while not IDLE
//   CkptFull, CkptCnt  occupancy (full is combinational, count registered)
//   ResErr             registered 1-cycle pulse on resolve of a non-live id
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepts flush, resolve, snapshot; retires the oldest entry
// ST_ROLL  | one cycle, Mable high, restore pointer presented on Mark
// ST_FLUSH | one cycle, FifoClean high, table already cleared

module fifo_rollback_ctrl #(
   parameter int PTRWIDE = 5,
   parameter int NCKPT   = 4,
   parameter int IDWIDE  = 2
) (
   input  logic               Clk,
   input  logic               Rest,
   input  logic [PTRWIDE-1:0] WrPtr,
   input  logic               SnapReq,
   output logic               SnapAck,
   output logic [IDWIDE-1:0]  SnapId,
   input  logic               ResValid,
   input  logic [IDWIDE-1:0]  ResId,
   input  logic               ResMiss,
   input  logic               FlushReq,
   output logic               Mable,
   output logic [PTRWIDE-1:0] Mark,
   output logic               FifoClean,
   output logic               Busy,
   output logic               CkptFull,
   output logic [IDWIDE:0]    CkptCnt,
   output logic               ResErr
);

   localparam logic [IDWIDE:0]   FULL_CNT = (IDWIDE+1)'(NCKPT);
   localparam logic [IDWIDE-1:0] ID_ONE   = IDWIDE'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_ROLL, ST_FLUSH} state_t;

   state_t state_q, state_d;

   logic [PTRWIDE-1:0] ptr_tbl [NCKPT];
   logic [NCKPT-1:0]   live_q, live_d;
   logic [NCKPT-1:0]   done_q, done_d;
   logic [IDWIDE-1:0]  alloc_q, alloc_d;
   logic [IDWIDE-1:0]  old_q, old_d;
   logic [IDWIDE:0]    count_q, count_d;

   logic               idle;
   logic               flush_acc;
   logic               res_acc;
   logic               res_live;
   logic               miss_acc;
   logic               hit_acc;
   logic               err_acc;
   logic               retire;
   logic [IDWIDE-1:0]  koff;
   logic [IDWIDE-1:0]  ent_off;
   logic [NCKPT-1:0]   roll_free;

   assign idle      = (state_q == ST_IDLE);
   assign flush_acc = idle && FlushReq;
   assign res_acc   = idle && ResValid && !FlushReq;
   assign res_live  = live_q[ResId];
   assign miss_acc  = res_acc && ResMiss && res_live;
   assign hit_acc   = res_acc && !ResMiss && res_live;
   assign err_acc   = res_acc && !res_live;

   assign CkptFull = (count_q == FULL_CNT);
   assign CkptCnt  = count_q;
   assign SnapId   = alloc_q;

   // Any miss request blocks the grant, even if it names a dead id, so that
   // the grant does not depend on the table lookup.
   assign SnapAck = SnapReq && idle && !CkptFull && !FlushReq && !(ResValid && ResMiss);

   // The oldest entry frees only in a quiet IDLE cycle. A rollback recomputes
   // the occupancy relative to the old pointer, so a retire is held off in
   // that cycle.
   assign retire = idle && !flush_acc && !miss_acc && (count_q != '0) && done_q[old_q];

   // This is the distance of the mispredicted entry from the oldest entry.
   // Every entry at that distance or further away is younger, so it is freed.
   assign koff = ResId - old_q;

   always_comb begin
      roll_free = '0;
      ent_off   = '0;
      for (int i = 0; i < NCKPT; i++) begin
         ent_off      = IDWIDE'(i) - old_q;
         roll_free[i] = (ent_off >= koff);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_acc)     state_d = ST_FLUSH;
            else if (miss_acc) state_d = ST_ROLL;
         end
         ST_ROLL:  state_d = ST_IDLE;
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      live_d  = live_q;
      done_d  = done_q;
      alloc_d = alloc_q;
      old_d   = old_q;
      count_d = count_q;
      if (flush_acc) begin
         live_d  = '0;
         done_d  = '0;
         alloc_d = '0;
         old_d   = '0;
         count_d = '0;
      end else if (miss_acc) begin
         live_d  = live_q & ~roll_free;
         done_d  = done_q & ~roll_free;
         alloc_d = ResId;
         count_d = {1'b0, koff};
      end else begin
         if (hit_acc) done_d[ResId] = 1'b1;
         if (SnapAck) begin
            live_d[alloc_q] = 1'b1;
            done_d[alloc_q] = 1'b0;
            alloc_d         = alloc_q + ID_ONE;
         end
         // The retire clear runs after the hit set. A repeated hit on the
         // retiring entry therefore does not leave a stale Done bit behind.
         if (retire) begin
            live_d[old_q] = 1'b0;
            done_d[old_q] = 1'b0;
            old_d         = old_q + ID_ONE;
         end
         case ({SnapAck, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         live_q  <= '0;
         done_q  <= '0;
         alloc_q <= '0;
         old_q   <= '0;
         count_q <= '0;
      end else begin
         live_q  <= live_d;
         done_q  <= done_d;
         alloc_q <= alloc_d;
         old_q   <= old_d;
         count_q <= count_d;
      end
   end

   // Pointer storage is qualified by the Live bits, so it needs no reset.
   always_ff @(posedge Clk) begin
      if (SnapAck) ptr_tbl[alloc_q] <= WrPtr;
   end

   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         Mable     <= 1'b0;
         Mark      <= '0;
         FifoClean <= 1'b0;
         Busy      <= 1'b0;
         ResErr    <= 1'b0;
      end else begin
         Mable     <= (state_d == ST_ROLL);
         FifoClean <= (state_d == ST_FLUSH);
         Busy      <= (state_d != ST_IDLE);
         ResErr    <= err_acc;
         if (miss_acc) Mark <= ptr_tbl[ResId];
      end
   end

endmodule

// File: tb/tb_fifo_rollback_ctrl.sv
module tb_fifo_rollback_ctrl;

   localparam int PW = 5;
   localparam int N  = 4;
   localparam int IW = 2;

   logic          Clk = 1'b0;
   logic          Rest;
   logic [PW-1:0] WrPtr;
   logic          SnapReq;
   logic          SnapAck;
   logic [IW-1:0] SnapId;
   logic          ResValid;
   logic [IW-1:0] ResId;
   logic          ResMiss;
   logic          FlushReq;
   logic          Mable;
   logic [PW-1:0] Mark;
   logic          FifoClean;
   logic          Busy;
   logic          CkptFull;
   logic [IW:0]   CkptCnt;
   logic          ResErr;

   fifo_rollback_ctrl #(.PTRWIDE(PW), .NCKPT(N), .IDWIDE(IW)) dut (
      .Clk(Clk), .Rest(Rest), .WrPtr(WrPtr), .SnapReq(SnapReq), .SnapAck(SnapAck),
      .SnapId(SnapId), .ResValid(ResValid), .ResId(ResId), .ResMiss(ResMiss),
      .FlushReq(FlushReq), .Mable(Mable), .Mark(Mark), .FifoClean(FifoClean),
      .Busy(Busy), .CkptFull(CkptFull), .CkptCnt(CkptCnt), .ResErr(ResErr)
   );

   always #5 Clk = ~Clk;

   // The reference model keeps checkpoints in program order in a queue.
   typedef struct { int id; int ptr; bit done; } ckpt_t;
   typedef struct {
      bit ack; int sid; bit full; bit mable; bit clean; bit busy;
      int cnt; int mark; bit err;
   } exp_t;

   ckpt_t m_q[$];
   int    m_alloc;
   int    m_mode;    // 0 idle, 1 rollback cycle, 2 flush cycle
   int    m_mark;
   bit    m_err;
   exp_t  sb[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check(string name, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int find_id(int k);
      foreach (m_q[i]) if (m_q[i].id == k) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_alloc = 0;
      m_mode  = 0;
      m_mark  = 0;
      m_err   = 0;
   endtask

   task automatic drive_zero();
      SnapReq = 0; WrPtr = '0; ResValid = 0; ResId = '0; ResMiss = 0; FlushReq = 0;
   endtask

   // Drive one cycle of stimulus, queue the expected response for this cycle,
   // then advance the model past the upcoming edge.
   task automatic step(bit snap, int wr, bit rv, int rid, bit rm, bit fl);
      exp_t e;
      int   idx;
      bit   ret;
      @(posedge Clk); #1;
      SnapReq = snap; WrPtr = wr[PW-1:0]; ResValid = rv; ResId = rid[IW-1:0];
      ResMiss = rm; FlushReq = fl;
      e.ack   = snap && (m_mode == 0) && (m_q.size() < N) && !fl && !(rv && rm);
      e.sid   = m_alloc;
      e.full  = (m_q.size() == N);
      e.mable = (m_mode == 1);
      e.clean = (m_mode == 2);
      e.busy  = (m_mode != 0);
      e.cnt   = m_q.size();
      e.mark  = m_mark;
      e.err   = m_err;
      sb.push_back(e);
      if (m_mode != 0) begin
         m_mode = 0;
         m_err  = 0;
      end else if (fl) begin
         m_q.delete();
         m_alloc = 0;
         m_mode  = 2;
         m_err   = 0;
      end else begin
         idx   = find_id(rid);
         m_err = rv && (idx < 0);
         if (rv && rm && idx >= 0) begin
            m_mark = m_q[idx].ptr;
            while (m_q.size() > idx) void'(m_q.pop_back());
            m_alloc = rid;
            m_mode  = 1;
         end else begin
            ret = (m_q.size() > 0) && m_q[0].done;
            if (rv && idx >= 0) m_q[idx].done = 1;
            if (e.ack) begin
               m_q.push_back('{m_alloc, wr % 32, 1'b0});
               m_alloc = (m_alloc + 1) % N;
            end
            if (ret) void'(m_q.pop_front());
         end
      end
   endtask

   task automatic rand_step();
      bit snap, rv, rm, fl;
      int rid, wr;
      snap = ($urandom_range(0, 9) < 6);
      rv   = ($urandom_range(0, 9) < 4);
      rm   = ($urandom_range(0, 9) < 2);
      fl   = ($urandom_range(0, 99) < 3);
      wr   = $urandom_range(0, 31);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
         rid = m_q[$urandom_range(0, m_q.size() - 1)].id;
      else
         rid = $urandom_range(0, N - 1);
      step(snap, wr, rv, rid, rm, fl);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge Clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("SnapAck", SnapAck, e.ack);
            if (e.ack) check("SnapId", SnapId, e.sid);
            check("CkptFull", CkptFull, e.full);
            check("Mable", Mable, e.mable);
            check("FifoClean", FifoClean, e.clean);
            check("Busy", Busy, e.busy);
            check("CkptCnt", CkptCnt, e.cnt);
            check("Mark", Mark, e.mark);
            check("ResErr", ResErr, e.err);
         end
      end
   end

   initial begin : stim
      Rest = 1'b1;
      drive_zero();
      model_reset();
      #12;
      check("rst_Mable", Mable, 0);
      check("rst_Busy", Busy, 0);
      check("rst_FifoClean", FifoClean, 0);
      check("rst_CkptCnt", CkptCnt, 0);
      check("rst_ResErr", ResErr, 0);
      check("rst_Mark", Mark, 0);
      Rest = 1'b0;

      // Three snapshots, then a miss on the middle entry.
      step(1, 3, 0, 0, 0, 0);
      step(1, 7, 0, 0, 0, 0);
      step(1, 9, 0, 0, 0, 0);
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 5, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // Fill the table, confirm a snapshot is refused while full, then wrap.
      for (int i = 0; i < N; i++) step(1, 10 + i, 0, 0, 0, 0);
      step(1, 20, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 21, 0, 0, 0, 0);

      // Flush, miss and snapshot all in the same cycle.
      step(1, 4, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0);

      // Out-of-order hits hold until the oldest resolves.
      for (int i = 0; i < 3; i++) step(1, 2 * i + 1, 0, 0, 0, 0);
      step(0, 0, 1, 2, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);

      // A miss on a freed id raises ResErr and does not roll back.
      step(0, 0, 1, 3, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 1500; i++) rand_step();

      // Assert the reset in the middle of a rollback.
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      step(1, 21, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      @(posedge Clk); #1;
      drive_zero();
      check("roll_Mable", Mable, 1);
      check("roll_Mark", Mark, 21);
      Rest = 1'b1;
      #1;
      check("abort_Mable", Mable, 0);
      check("abort_Busy", Busy, 0);
      check("abort_Mark", Mark, 0);
      check("abort_CkptCnt", CkptCnt, 0);
      check("abort_FifoClean", FifoClean, 0);
      check("abort_ResErr", ResErr, 0);
      #20;
      Rest = 1'b0;
      model_reset();
      for (int i = 0; i < 100; i++) rand_step();
      step(0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clk);
      #1;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected responses left unchecked", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
